// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the ibex instruction/data Avalon-MM arbiter.
package avalon_arb_pkg;

   typedef enum logic {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/avalon_arb_tag_fifo.sv
// Owner-tag FIFO recording which master issued each outstanding pipelined read.
module avalon_arb_tag_fifo
   import avalon_arb_pkg::*;
#(
   parameter int MaxOutstanding = 4,
   parameter int CntW           = $clog2(MaxOutstanding) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push,
   input  owner_e          push_tag,
   input  logic            pop,
   output owner_e          pop_tag,
   output logic            full,
   output logic            empty,
   output logic [CntW-1:0] count
);

   localparam int              PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

   owner_e          mem [MaxOutstanding];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: tag storage has no reset; only entries covered by count are ever read.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= push_tag;
   end

   assign pop_tag = mem[rd_ptr];
   assign full    = (count == CntW'(MaxOutstanding));
   assign empty   = (count == '0);

endmodule

// File: rtl/avalon_ibex_bus_arbiter.sv
// Muxes the ibex instruction and data Avalon masters onto one Avalon-MM port.
// Define IBEX_AVALON_ARB_RR_EN for round-robin tie breaking; default is data-over-instruction.
module avalon_ibex_bus_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int MaxOutstanding = 4,
   parameter int AddrWidth      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [AddrWidth-1:0] avs_instr_address,
   input  logic                 avs_instr_read,
   output logic [31:0]          avs_instr_readdata,
   output logic                 avs_instr_waitrequest,
   output logic                 avs_instr_readdatavalid,
   input  logic [AddrWidth-1:0] avs_data_address,
   input  logic [3:0]           avs_data_byteenable,
   input  logic                 avs_data_read,
   input  logic                 avs_data_write,
   input  logic [31:0]          avs_data_writedata,
   output logic [31:0]          avs_data_readdata,
   output logic                 avs_data_waitrequest,
   output logic                 avs_data_readdatavalid,
   output logic [1:0]           avs_data_response,
   output logic [AddrWidth-1:0] avm_address,
   output logic [3:0]           avm_byteenable,
   output logic                 avm_read,
   output logic                 avm_write,
   output logic [31:0]          avm_writedata,
   input  logic [31:0]          avm_readdata,
   input  logic                 avm_waitrequest,
   input  logic                 avm_readdatavalid,
   input  logic [1:0]           avm_response
);

   localparam int CntW = $clog2(MaxOutstanding) + 1;

   arb_state_e      state_q;
   owner_e          owner_q;
   logic            err_q;
`ifdef IBEX_AVALON_ARB_RR_EN
   owner_e          last_grant_q;
`endif

   logic            req_instr, req_data, elig_instr, elig_data;
   logic            active, accept, push, pop, full, empty;
   owner_e          winner, sel, head_tag;
   logic [CntW-1:0] tag_count;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      req_instr  = avs_instr_read;
      req_data   = avs_data_read | avs_data_write;
      elig_instr = req_instr & ~full;
      elig_data  = req_data & (~avs_data_read | ~full);
      winner     = elig_data ? OWNER_DATA : OWNER_INSTR;
`ifdef IBEX_AVALON_ARB_RR_EN
      if (elig_instr && elig_data)
         winner = (last_grant_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
`endif
      if (state_q == ARB_HOLD) begin
         sel    = owner_q;
         active = (owner_q == OWNER_DATA) ? req_data : req_instr;
      end else begin
         sel    = winner;
         active = elig_instr | elig_data;
      end
      active &= ~rst_i;
   end

   // A simultaneous data read and write issues the read.
   assign avm_read       = active & ((sel == OWNER_INSTR) | avs_data_read);
   assign avm_write      = active & (sel == OWNER_DATA) & ~avs_data_read;
   assign avm_address    = (sel == OWNER_DATA) ? avs_data_address : avs_instr_address;
   assign avm_byteenable = (sel == OWNER_DATA) ? avs_data_byteenable : 4'hF;
   assign avm_writedata  = avs_data_writedata;

   assign accept                = active & ~avm_waitrequest;
   assign avs_instr_waitrequest = ~(accept & (sel == OWNER_INSTR));
   assign avs_data_waitrequest  = ~(accept & (sel == OWNER_DATA));

   assign push = avm_read & ~avm_waitrequest;
   assign pop  = avm_readdatavalid & ~empty & ~rst_i;

   assign avs_instr_readdatavalid = pop & (head_tag == OWNER_INSTR);
   assign avs_data_readdatavalid  = pop & (head_tag == OWNER_DATA);
   assign avs_instr_readdata      = avm_readdata;
   assign avs_data_readdata       = avm_readdata;
   assign avs_data_response       = avs_data_readdatavalid ? avm_response : RESP_OKAY;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWNER_DATA;
         err_q        <= 1'b0;
`ifdef IBEX_AVALON_ARB_RR_EN
         last_grant_q <= OWNER_INSTR;
`endif
      end else begin
         case (state_q)
            ARB_IDLE: if (active && avm_waitrequest) begin
               state_q <= ARB_HOLD;
               owner_q <= sel;
            end
            ARB_HOLD: if (!avm_waitrequest) state_q <= ARB_IDLE;
            default:  state_q <= ARB_IDLE;
         endcase
         if (avm_readdatavalid && empty) err_q <= 1'b1;
`ifdef IBEX_AVALON_ARB_RR_EN
         if (accept) last_grant_q <= sel;
`endif
      end
   end

   avalon_arb_tag_fifo #(
      .MaxOutstanding (MaxOutstanding)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (push),
      .push_tag (sel),
      .pop      (pop),
      .pop_tag  (head_tag),
      .full     (full),
      .empty    (empty),
      .count    (tag_count)
   );

   a_no_rd_wr:   assert property (@(posedge clk_i) disable iff (rst_i) !(avs_data_read && avs_data_write));
   a_count_max:  assert property (@(posedge clk_i) disable iff (rst_i) tag_count <= CntW'(MaxOutstanding));
   a_err_sticky: assert property (@(posedge clk_i) disable iff (rst_i) err_q |=> err_q);

endmodule
